// File: rtl/regfile_scoreboard.sv
// Multi-port register file with optional write-to-read bypass and per-register
// pending-write counters used by decode for RAW hazard detection and issue gating.
module regfile_scoreboard #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  parameter int PEND_MAX = 3,
  localparam int AW      = $clog2(NREGS),
  localparam int PW      = $clog2(PEND_MAX + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREAD*AW-1:0]   rd_addr,
  output logic [NREAD*XLEN-1:0] rd_data,
  output logic [NREAD-1:0]      rd_ready,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [XLEN-1:0]       wr_data,
  input  logic                  claim_en,
  input  logic [AW-1:0]         claim_addr,
  output logic                  claim_ready,
  input  logic                  flush,
  output logic                  wr_underflow
);

  localparam logic [PW-1:0] PMAX = PW'(PEND_MAX);

  logic [XLEN-1:0] regs     [NREGS];
  logic [PW-1:0]   pend     [NREGS];
  logic [PW-1:0]   pend_nxt [NREGS];
  logic [XLEN-1:0] rdat     [NREAD];
  logic [NREAD-1:0] rrdy;

  logic wr_eff;
  logic wr_dec;
  logic claim_zero;
  logic claim_fire;

  always_comb begin
    wr_eff     = wr_en && !((ZERO_REG != 0) && (wr_addr == '0));
    wr_dec     = wr_eff && (pend[wr_addr] != '0);
    claim_zero = (ZERO_REG != 0) && (claim_addr == '0);
    claim_ready = claim_zero || (pend[claim_addr] != PMAX) ||
                  (wr_en && (wr_addr == claim_addr));
    claim_fire = claim_en && claim_ready && !claim_zero;
  end

  genvar gi;
  generate
    for (gi = 0; gi < NREAD; gi++) begin : g_rd
      logic [AW-1:0] a;
      logic          zero_hit;
      logic          wr_hit;

      always_comb begin
        a        = rd_addr[gi*AW +: AW];
        zero_hit = (ZERO_REG != 0) && (a == '0);
        wr_hit   = (BYPASS != 0) && wr_eff && (wr_addr == a);
        if (zero_hit) begin
          rdat[gi] = '0;
          rrdy[gi] = 1'b1;
        end else begin
          rdat[gi] = wr_hit ? wr_data : regs[a];
          rrdy[gi] = (pend[a] == '0) || (wr_hit && (pend[a] == PW'(1)));
        end
      end
    end
  endgenerate

  always_comb begin
    rd_data = '0;
    for (int unsigned i = 0; i < NREAD; i++) begin
      rd_data[i*XLEN +: XLEN] = rdat[i];
    end
    rd_ready = rrdy;
  end

  // A same-cycle release and claim on one register cancel out, which is what
  // lets a saturated counter accept the claim.
  always_comb begin
    for (int unsigned r = 0; r < NREGS; r++) begin
      pend_nxt[r] = pend[r];
      if (claim_fire && (claim_addr == AW'(r)) && !(wr_dec && (wr_addr == AW'(r)))) begin
        pend_nxt[r] = pend[r] + 1'b1;
      end else if (wr_dec && (wr_addr == AW'(r)) && !(claim_fire && (claim_addr == AW'(r)))) begin
        pend_nxt[r] = pend[r] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned r = 0; r < NREGS; r++) begin
        regs[r] <= '0;
        pend[r] <= '0;
      end
      wr_underflow <= 1'b0;
    end else begin
      if (wr_eff) begin
        regs[wr_addr] <= wr_data;
        if (pend[wr_addr] == '0) begin
          wr_underflow <= 1'b1;
        end
      end
      for (int unsigned r = 0; r < NREGS; r++) begin
        pend[r] <= flush ? '0 : pend_nxt[r];
      end
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: directed vector table plus randomized traffic
// compared against an array-based model of the register/scoreboard rules.
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_ready;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        claim_en;
  logic [4:0]  claim_addr;
  logic        claim_ready;
  logic        flush;
  logic        wr_underflow;

  int n_checks = 0;
  int n_fail   = 0;

  regfile_scoreboard #(
    .XLEN(32), .NREGS(32), .NREAD(2), .ZERO_REG(1), .BYPASS(1), .PEND_MAX(3)
  ) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_ready(rd_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .claim_en(claim_en), .claim_addr(claim_addr), .claim_ready(claim_ready),
    .flush(flush), .wr_underflow(wr_underflow)
  );

  always #5 clk = ~clk;

  // Reference state: plain integers, one entry per architectural register.
  int unsigned mregs [32];
  int          mpend [32];
  int          muf;

  typedef struct {
    logic        rst;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        ce;
    logic [4:0]  ca;
    logic        fl;
    logic [4:0]  r0;
    logic [4:0]  r1;
    logic [31:0] e0;
    logic [31:0] e1;
    logic [1:0]  erdy;
    logic        ecr;
    logic        euf;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_rd(input int a);
    if (a == 0) return 32'h0;
    if (wr_en && int'(wr_addr) == a) return wr_data;
    return mregs[a];
  endfunction

  function automatic logic m_ready(input int a);
    if (a == 0) return 1'b1;
    return (mpend[a] == 0) || (wr_en && int'(wr_addr) == a && mpend[a] == 1);
  endfunction

  function automatic logic m_cr();
    int ca = int'(claim_addr);
    return (ca == 0) || (mpend[ca] < 3) || (wr_en && int'(wr_addr) == ca);
  endfunction

  task automatic m_update();
    int  wa = int'(wr_addr);
    int  ca = int'(claim_addr);
    logic cr = m_cr();
    logic released = 1'b0;
    if (rst) begin
      for (int r = 0; r < 32; r++) begin
        mregs[r] = 0;
        mpend[r] = 0;
      end
      muf = 0;
      return;
    end
    if (wr_en && wa != 0) begin
      mregs[wa] = wr_data;
      if (mpend[wa] == 0) muf = 1;
      else released = 1'b1;
    end
    if (flush) begin
      for (int r = 0; r < 32; r++) mpend[r] = 0;
    end else begin
      if (released) mpend[wa] = mpend[wa] - 1;
      if (claim_en && cr && ca != 0) mpend[ca] = mpend[ca] + 1;
    end
  endtask

  task automatic idle_inputs();
    rst = 0; wr_en = 0; wr_addr = 0; wr_data = 0;
    claim_en = 0; claim_addr = 0; flush = 0; rd_addr = 0;
  endtask

  // Inputs are already driven; let them settle, update the model, take the edge.
  task automatic tick();
    m_update();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle_inputs();
    for (int r = 0; r < 32; r++) begin
      mregs[r] = 0;
      mpend[r] = 0;
    end
    muf = 0;
    #1;
    rst = 1;
    tick();
    idle_inputs();
    #1;

    chk("reset_claim_ready", {63'd0, claim_ready}, 64'd1);
    chk("reset_underflow", {63'd0, wr_underflow}, 64'd0);
    for (int a = 0; a < 32; a++) begin
      rd_addr = {5'(31 - a), 5'(a)};
      #1;
      chk("reset_rd_data", rd_data, 64'd0);
      chk("reset_rd_ready", {62'd0, rd_ready}, 64'd3);
    end
    tick();

    //            rst we wa   wd            ce ca  fl r0  r1  e0            e1            erdy   cr  uf
    vecs.push_back('{0, 0, 0,  32'h0,        1, 5,  0, 5,  5,  32'h0,        32'h0,        2'b11, 1, 0});
    vecs.push_back('{0, 0, 0,  32'h0,        0, 0,  0, 5,  6,  32'h0,        32'h0,        2'b10, 1, 0});
    vecs.push_back('{0, 1, 5,  32'hDEADBEEF, 0, 0,  0, 5,  5,  32'hDEADBEEF, 32'hDEADBEEF, 2'b11, 1, 0});
    vecs.push_back('{0, 0, 0,  32'h0,        0, 0,  0, 5,  0,  32'hDEADBEEF, 32'h0,        2'b11, 1, 0});
    vecs.push_back('{0, 0, 0,  32'h0,        1, 7,  0, 7,  7,  32'h0,        32'h0,        2'b11, 1, 0});
    vecs.push_back('{0, 0, 0,  32'h0,        1, 7,  0, 7,  7,  32'h0,        32'h0,        2'b00, 1, 0});
    vecs.push_back('{0, 0, 0,  32'h0,        1, 7,  0, 7,  7,  32'h0,        32'h0,        2'b00, 1, 0});
    vecs.push_back('{0, 0, 0,  32'h0,        1, 7,  0, 7,  7,  32'h0,        32'h0,        2'b00, 0, 0});
    vecs.push_back('{0, 0, 0,  32'h0,        0, 7,  0, 7,  7,  32'h0,        32'h0,        2'b00, 0, 0});
    vecs.push_back('{0, 1, 7,  32'hA5A5A5A5, 1, 7,  0, 7,  7,  32'hA5A5A5A5, 32'hA5A5A5A5, 2'b00, 1, 0});
    vecs.push_back('{0, 0, 0,  32'h0,        0, 7,  0, 7,  7,  32'hA5A5A5A5, 32'hA5A5A5A5, 2'b00, 0, 0});
    vecs.push_back('{0, 1, 0,  32'h12345678, 1, 0,  0, 0,  0,  32'h0,        32'h0,        2'b11, 1, 0});
    vecs.push_back('{0, 0, 0,  32'h0,        0, 0,  0, 0,  0,  32'h0,        32'h0,        2'b11, 1, 0});
    vecs.push_back('{0, 1, 3,  32'h33333333, 0, 0,  0, 3,  3,  32'h33333333, 32'h33333333, 2'b11, 1, 0});
    vecs.push_back('{0, 0, 0,  32'h0,        0, 0,  0, 3,  3,  32'h33333333, 32'h33333333, 2'b11, 1, 1});
    vecs.push_back('{0, 0, 0,  32'h0,        1, 4,  0, 4,  4,  32'h0,        32'h0,        2'b11, 1, 1});
    vecs.push_back('{0, 0, 0,  32'h0,        1, 4,  0, 4,  4,  32'h0,        32'h0,        2'b00, 1, 1});
    vecs.push_back('{0, 0, 0,  32'h0,        1, 4,  1, 4,  4,  32'h0,        32'h0,        2'b00, 1, 1});
    vecs.push_back('{0, 0, 0,  32'h0,        0, 7,  0, 4,  7,  32'h0,        32'hA5A5A5A5, 2'b11, 1, 1});
    vecs.push_back('{0, 0, 0,  32'h0,        1, 9,  0, 9,  3,  32'h0,        32'h33333333, 2'b11, 1, 1});
    vecs.push_back('{1, 1, 9,  32'h000000FF, 0, 0,  0, 9,  9,  32'h000000FF, 32'h000000FF, 2'b11, 1, 1});
    vecs.push_back('{0, 0, 0,  32'h0,        0, 0,  0, 9,  3,  32'h0,        32'h0,        2'b11, 1, 0});

    foreach (vecs[i]) begin
      rst = vecs[i].rst; wr_en = vecs[i].we; wr_addr = vecs[i].wa; wr_data = vecs[i].wd;
      claim_en = vecs[i].ce; claim_addr = vecs[i].ca; flush = vecs[i].fl;
      rd_addr = {vecs[i].r1, vecs[i].r0};
      #1;
      chk($sformatf("vec%0d_rd_data", i), rd_data, {vecs[i].e1, vecs[i].e0});
      chk($sformatf("vec%0d_rd_ready", i), {62'd0, rd_ready}, {62'd0, vecs[i].erdy});
      chk($sformatf("vec%0d_claim_ready", i), {63'd0, claim_ready}, {63'd0, vecs[i].ecr});
      chk($sformatf("vec%0d_underflow", i), {63'd0, wr_underflow}, {63'd0, vecs[i].euf});
      tick();
    end

    for (int c = 0; c < 3000; c++) begin
      rst        = ($urandom_range(0, 99) == 0);
      flush      = ($urandom_range(0, 29) == 0);
      wr_en      = $urandom_range(0, 1) == 1;
      wr_addr    = 5'($urandom_range(0, 7));
      wr_data    = $urandom;
      claim_en   = $urandom_range(0, 2) != 0;
      claim_addr = 5'($urandom_range(0, 7));
      if (wr_en && claim_en && wr_addr == claim_addr && wr_addr != 0 && mpend[wr_addr] == 0)
        claim_addr = 5'((int'(wr_addr) + 1) % 8);
      rd_addr    = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      #1;
      chk("rand_rd_data0", {32'd0, rd_data[31:0]}, {32'd0, m_rd(int'(rd_addr[4:0]))});
      chk("rand_rd_data1", {32'd0, rd_data[63:32]}, {32'd0, m_rd(int'(rd_addr[9:5]))});
      chk("rand_rd_ready", {62'd0, rd_ready},
          {62'd0, m_ready(int'(rd_addr[9:5])), m_ready(int'(rd_addr[4:0]))});
      chk("rand_claim_ready", {63'd0, claim_ready}, {63'd0, m_cr()});
      chk("rand_underflow", {63'd0, wr_underflow}, 64'(muf));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised successor to the core's 2-read/1-write register file, for the pipelined RV32I datapath.
- Adds a configurable number of read ports, optional write-to-read bypass, and per-register pending-write counters (scoreboard).
- Decode uses the scoreboard to detect RAW hazards and to gate issue.
- Sits between decode/issue (claims, reads) and writeback (writes, releases).

Parameters:
XLEN, 32, data width of each register
NREGS, 32, number of architectural registers (power of two, >=2); AW = $clog2(NREGS)
NREAD, 2, number of read ports (1..4)
ZERO_REG, 1, 1: register 0 reads 0, ignores writes and claims
BYPASS, 1, 1: same-cycle writeback data forwarded to matching read ports
PEND_MAX, 3, maximum in-flight writes per register; counter width PW = $clog2(PEND_MAX+1)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
rd_addr  in  NREAD*AW  read addresses; port i at [i*AW +: AW]
rd_data  out  NREAD*XLEN  read data; port i at [i*XLEN +: XLEN]
rd_ready  out  NREAD  port i operand has no outstanding writer (or is bypassed)
wr_en  in  1  writeback strobe
wr_addr  in  AW  writeback destination
wr_data  in  XLEN  writeback data
claim_en  in  1  issue marks a destination as pending
claim_addr  in  AW  destination being claimed
claim_ready  out  1  claim will be accepted this cycle
flush  in  1  squash: clear all pending counters
wr_underflow  out  1  sticky error: write to a register with pending count 0

Behaviour:
- Reset (rst=1 at a clk edge): all registers <= 0, all pending counters <= 0, wr_underflow <= 0.
  - Takes priority over every other input in that cycle.
  - After reset, every rd_data = 0, rd_ready = all ones, claim_ready = 1.
  - Reset mid-operation discards all in-flight claims; no state is retained.
- Reads are combinational, zero latency. Per port i:
  - ZERO_REG and rd_addr==0: rd_data = 0, rd_ready = 1.
  - Else if BYPASS and wr_en and wr_addr==rd_addr (and not (ZERO_REG and wr_addr==0)): rd_data = wr_data.
  - Else rd_data = stored value.
- rd_ready[i] = (pend[rd_addr]==0), or (BYPASS and wr_en and wr_addr==rd_addr and pend[rd_addr]==1).
- Writes, on the clk edge:
  - wr_en updates reg[wr_addr] <= wr_data, unless ZERO_REG and wr_addr==0 (dropped, no counter change).
  - If pend[wr_addr]>0, decrement it.
  - If pend[wr_addr]==0, the data is still written, the counter stays 0, and wr_underflow <= 1 (sticky until rst).
- Claims:
  - claim_ready = 0 only when pend[claim_addr]==PEND_MAX, with no write to claim_addr in the same cycle. It is combinational and evaluated even when claim_en=0.
  - claim_en and claim_ready: pend[claim_addr] increments.
  - claim_en and not claim_ready: no effect; issue must hold and retry.
  - ZERO_REG and claim_addr==0: claim_ready=1, counter untouched.
- Simultaneous write and claim to the same register: net counter change is 0. Decrement and increment cancel, so a full counter accepts the claim.
- Flush: all counters <= 0 at the edge; any same-cycle claim is dropped.
  - A same-cycle write still updates data. Underflow is still checked against the pre-flush count.
  - Register contents are otherwise unchanged.
- Multiple read ports may use the same address; each port is independent.
- Counter arithmetic is unsigned, PW bits. It never wraps: increment is gated by claim_ready, and decrement is gated by pend>0.
- Implementation: storage as flip-flop array; no initial blocks (reset defines state).

Test Plan:
- Reset then read all: rst=1 one cycle -> rd_data=0 on all ports for addresses 0..NREGS-1, rd_ready all 1, claim_ready=1, wr_underflow=0.
- Claim/write/read: claim x5, next cycle rd_addr0=5 -> rd_ready[0]=0. Write x5=0xDEADBEEF -> same cycle rd_data0=0xDEADBEEF, rd_ready[0]=1 (BYPASS=1). Next cycle stored value 0xDEADBEEF, pend=0.
- Saturation: claim x7 three times -> claim_ready=0 with claim_addr=7. Fourth claim_en has no effect. Same cycle with wr_en to x7 -> claim accepted, pend stays 3.
- x0 handling: write x0=0x12345678 and claim x0 -> rd_data for x0 stays 0, rd_ready=1, wr_underflow stays 0.
- Underflow and flush: write x3 with pend 0 -> x3 updated, wr_underflow=1 and held. Claim x4 twice, then flush with claim_en on x4 -> pend[x4]=0, rd_ready for x4 = 1.
- Reset mid-flight: claim x9, assert rst with wr_en to x9=0xFF the same cycle -> x9 reads 0, pend 0, wr_underflow 0.
